mdu: RTL and testbench
======================

# mdu

Multi-cycle multiply/divide unit for the MIPS datapath, sitting in the execute stage beside `alu`. It accepts the same 32-bit operand pair A/B plus an operation code, and iterates MULT/MULTU/DIV/DIVU over a fixed latency. It owns the architectural HI/LO registers and serves MFHI/MFLO/MTHI/MTLO. `busy` tells hazard logic when to stall dependent instructions.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles for MULT/MULTU (≥1).
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU (≥1).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `A`  in  32  operand rs (dividend/multiplicand; MTHI/MTLO source).
- `B`  in  32  operand rt (divisor/multiplier).
- `Op`  in  3  operation code (package constants).
- `Start`  in  1  issue strobe; Op/A/B sampled when high.
- `Out`  out  32  read data: LO when Op=MFLO, else HI; combinational from registers.
- `Busy`  out  1  high while an operation is in flight.

## Operation
- Op codes: MULT=0, MULTU=1, DIV=2, DIVU=3, MFHI=4, MFLO=5, MTHI=6, MTLO=7.
- FSM states: IDLE, MUL_RUN, DIV_RUN.
- IDLE with Start and Op∈{MULT,MULTU}: latch {HI',LO'} = 64-bit product (signed for MULT), counter ← MULT_CYCLES−1, go to MUL_RUN.
- IDLE with Start and Op∈{DIV,DIVU}: latch LO' = quotient, HI' = remainder, counter ← DIV_CYCLES−1, go to DIV_RUN.
- Signed divide: quotient truncates toward zero; remainder takes sign of dividend. 0x80000000 / 0xFFFFFFFF gives LO'=0x80000000, HI'=0.
- Divide by zero (B=0): operation runs the full latency; HI/LO are left unchanged at completion.
- RUN states: counter decrements each cycle. At counter=0, HI←HI', LO←LO', return to IDLE.
- MTHI/MTLO with Start in IDLE: HI or LO ← A at that edge. No busy period.
- MFHI/MFLO need no Start; Out is always valid combinationally.
- Start while Busy: ignored entirely, including MTHI/MTLO. Upstream must stall on `Start|Busy`.
- Op values MFHI/MFLO with Start: no state change.
- Out during RUN shows the old HI/LO. New values are visible only after Busy falls.

## Timing
- Reset: state IDLE, HI=0, LO=0, counter=0, Busy=0, Out=0. A reset mid-operation cancels it and discards the pending result.
- Start sampled at edge E0. Busy is high from E0 for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES), falling at edge E0+N.
- HI/LO are written at that same edge E0+N.
- A new Start is accepted at edge E0+N+1 at the earliest, i.e. the first cycle with Busy=0.
- MTHI/MTLO: HI/LO updated at the sampling edge. Out reflects it in the next cycle.
- Busy is a registered output, never combinational from Start.

## Structure
- Shared package `mdu_pkg`:
  - Op code localparams MDU_MULT…MDU_MTLO (3-bit).
  - FSM state encoding.
  - Default latency constants.
- The decode stage imports the same package to generate Op.
- One sub-module: `mdu_calc`, purely combinational. It maps {A, B, Op} to a 64-bit result {hi, lo} and a div_by_zero flag.
- `mdu` holds the FSM, counter, pending registers and HI/LO.

## Test plan
- MULT A=0xFFFFFFFE (−2), B=3, Start 1 cycle:
  - Busy high 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - MULTU with the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=−7 (0xFFFFFFF9), B=2:
  - After 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU A=7, B=2 gives LO=3, HI=1.
- Divide by zero and overflow:
  - DIVU A=5, B=0 with HI=0x11, LO=0x22: Busy for 10 cycles, then HI/LO unchanged.
  - DIV 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
- MTHI A=0xDEAD then MTLO A=0xBEEF (back-to-back, Busy stays 0):
  - Op=MFHI gives Out=0xDEAD.
  - Op=MFLO gives Out=0xBEEF.
- Start MTLO A=0x1234 during MULT busy:
  - Ignored.
  - Final LO equals the product.
  - Out shows the old LO until Busy falls.
- Reset asserted in cycle 3 of DIV:
  - Next cycle Busy=0, HI=LO=0.
  - No late write occurs at cycle 10.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM encoding and default latencies.
// The decode stage imports this package to generate Op.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MFHI  = 3'd4;
  localparam logic [2:0] MDU_MFLO  = 3'd5;
  localparam logic [2:0] MDU_MTHI  = 3'd6;
  localparam logic [2:0] MDU_MTLO  = 3'd7;

  localparam int unsigned MDU_MULT_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES  = 10;

  typedef enum logic [1:0] {
    StIdle,
    StMulRun,
    StDivRun
  } mdu_state_e;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath: {A, B, Op} -> 64-bit {hi, lo} plus a divide-by-zero flag.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_op,
  output logic [63:0] o_result,
  output logic        o_div_by_zero
);

  logic        w_signed;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_divisor;
  logic [31:0] w_quo_mag;
  logic [31:0] w_rem_mag;
  logic [63:0] w_prod_mag;

  // Signed ops work on magnitudes; this keeps 0x80000000 / -1 well defined.
  assign w_signed   = (i_op == MDU_MULT) || (i_op == MDU_DIV);
  assign w_neg_a    = w_signed & i_a[31];
  assign w_neg_b    = w_signed & i_b[31];
  assign w_mag_a    = w_neg_a ? -i_a : i_a;
  assign w_mag_b    = w_neg_b ? -i_b : i_b;
  assign w_prod_mag = {32'd0, w_mag_a} * {32'd0, w_mag_b};
  assign w_divisor  = (i_b == 32'd0) ? 32'd1 : w_mag_b;
  assign w_quo_mag  = w_mag_a / w_divisor;
  assign w_rem_mag  = w_mag_a % w_divisor;

  assign o_div_by_zero = is_div_op(i_op) && (i_b == 32'd0);

  always_comb begin
    o_result = (w_neg_a ^ w_neg_b) ? -w_prod_mag : w_prod_mag;
    if (is_div_op(i_op)) begin
      o_result[63:32] = w_neg_a ? -w_rem_mag : w_rem_mag;
      o_result[31:0]  = (w_neg_a ^ w_neg_b) ? -w_quo_mag : w_quo_mag;
    end
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit: owns HI/LO, runs MULT/DIV over a fixed latency, serves MF/MT ops.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  Op,
  input  logic        Start,
  output logic [31:0] Out,
  output logic        Busy
);

  localparam logic [31:0] MulCntInit = 32'(MULT_CYCLES - 1);
  localparam logic [31:0] DivCntInit = 32'(DIV_CYCLES - 1);

  mdu_state_e  r_state;
  mdu_state_e  w_state_next;
  logic [31:0] r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        r_pend_dbz;

  logic        w_idle;
  logic        w_done;
  logic        w_accept_mul;
  logic        w_accept_div;
  logic        w_accept_mthi;
  logic        w_accept_mtlo;
  logic [63:0] w_calc_result;
  logic        w_calc_dbz;

  mdu_calc u_calc (
    .i_a           (A),
    .i_b           (B),
    .i_op          (Op),
    .o_result      (w_calc_result),
    .o_div_by_zero (w_calc_dbz)
  );

  // Start is only honoured in IDLE; anything issued while busy is dropped.
  assign w_accept_mul  = w_idle & Start & is_mul_op(Op);
  assign w_accept_div  = w_idle & Start & is_div_op(Op);
  assign w_accept_mthi = w_idle & Start & (Op == MDU_MTHI);
  assign w_accept_mtlo = w_idle & Start & (Op == MDU_MTLO);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept_mul) begin
          w_state_next = StMulRun;
        end else if (w_accept_div) begin
          w_state_next = StDivRun;
        end
      end
      StMulRun, StDivRun: begin
        if (r_cnt == 32'd0) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_idle = (r_state == StIdle);
    Busy   = !w_idle;
    w_done = !w_idle && (r_cnt == 32'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= 32'd0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_pend_hi  <= 32'd0;
      r_pend_lo  <= 32'd0;
      r_pend_dbz <= 1'b0;
    end else begin
      if (w_accept_mul || w_accept_div) begin
        r_pend_hi  <= w_calc_result[63:32];
        r_pend_lo  <= w_calc_result[31:0];
        r_pend_dbz <= w_calc_dbz;
        r_cnt      <= w_accept_mul ? MulCntInit : DivCntInit;
      end else if (r_cnt != 32'd0) begin
        r_cnt <= r_cnt - 32'd1;
      end
      if (w_done && !r_pend_dbz) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
      if (w_accept_mthi) begin
        r_hi <= A;
      end
      if (w_accept_mtlo) begin
        r_lo <= A;
      end
    end
  end

  assign Out = (Op == MDU_MFLO) ? r_lo : r_hi;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: driver pushes expected reads and busy lengths, monitors pop and compare.
module tb_mdu;
  import mdu_pkg::*;

  localparam int unsigned MulN = 5;
  localparam int unsigned DivN = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  Op;
  logic        Start;
  logic [31:0] Out;
  logic        Busy;

  mdu #(
    .MULT_CYCLES (MulN),
    .DIV_CYCLES  (DivN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .Op    (Op),
    .Start (Start),
    .Out   (Out),
    .Busy  (Busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  int          busy_q[$];
  logic        rd_valid = 1'b0;

  // Reference state: architectural HI/LO plus one pending result.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  bit          p_upd;
  bit          m_pending = 1'b0;

  logic [31:0] mon_exp;
  string       mon_name;
  int          busy_run = 0;
  int          busy_exp;

  always @(negedge clk) begin
    if (rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL read_underflow: got Out=%h with no expectation queued", Out);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if (Out !== mon_exp) begin
          errors++;
          $display("FAIL %s: Out=%h expected %h", mon_name, Out, mon_exp);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (Busy === 1'b1) begin
      busy_run++;
    end else if (busy_run > 0) begin
      checks++;
      if (busy_q.size() == 0) begin
        errors++;
        $display("FAIL busy_unexpected: busy for %0d cycles, none expected", busy_run);
      end else begin
        busy_exp = busy_q.pop_front();
        if (busy_run != busy_exp) begin
          errors++;
          $display("FAIL busy_len: busy for %0d cycles expected %0d", busy_run, busy_exp);
        end
      end
      busy_run = 0;
    end
  end

  function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo, output bit upd);
    longint x;
    longint y;
    longint q;
    longint r;
    upd = 1'b1;
    hi  = 32'd0;
    lo  = 32'd0;
    if (op == MDU_MULT || op == MDU_DIV) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    if (is_mul_op(op)) begin
      q  = x * y;
      hi = q[63:32];
      lo = q[31:0];
    end else if (b == 32'd0) begin
      upd = 1'b0;
    end else begin
      q  = x / y;
      r  = x % y;
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int cut);
    Op    = op;
    A     = a;
    B     = b;
    Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    if (!m_pending) begin
      if (is_mul_op(op) || is_div_op(op)) begin
        ref_op(op, a, b, p_hi, p_lo, p_upd);
        m_pending = 1'b1;
        if (cut > 0) busy_q.push_back(cut);
        else busy_q.push_back(is_mul_op(op) ? int'(MulN) : int'(DivN));
      end else if (op == MDU_MTHI) begin
        m_hi = a;
      end else if (op == MDU_MTLO) begin
        m_lo = a;
      end
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (Busy === 1'b1 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (Busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: Busy=%b after %0d cycles, expected 0", Busy, n);
    end
    if (m_pending) begin
      if (p_upd) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
      m_pending = 1'b0;
    end
  endtask

  task automatic rd(input logic [2:0] op, input string n);
    Op       = op;
    Start    = 1'b0;
    rd_valid = 1'b1;
    exp_q.push_back((op == MDU_MFLO) ? m_lo : m_hi);
    name_q.push_back(n);
    @(posedge clk);
    #1;
    rd_valid = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string n);
    issue(op, a, b, 0);
    wait_done();
    rd(MDU_MFHI, {n, "_hi"});
    rd(MDU_MFLO, {n, "_lo"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int          r;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    reset = 1'b1;
    Start = 1'b0;
    Op    = MDU_MFHI;
    A     = 32'd0;
    B     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    rd(MDU_MFHI, "reset_hi");
    rd(MDU_MFLO, "reset_lo");
    rd(MDU_MULT, "reset_out_default");

    run_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3, "mult_neg");
    run_op(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, "multu");
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
    run_op(MDU_DIVU, 32'd7, 32'd2, "divu");

    issue(MDU_MTHI, 32'h11, 32'd0, 0);
    issue(MDU_MTLO, 32'h22, 32'd0, 0);
    run_op(MDU_DIVU, 32'd5, 32'd0, "div_by_zero");
    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");

    issue(MDU_MTHI, 32'hDEAD, 32'd0, 0);
    issue(MDU_MTLO, 32'hBEEF, 32'd0, 0);
    rd(MDU_MFHI, "mthi");
    rd(MDU_MFLO, "mtlo");

    issue(MDU_MULT, 32'd7, 32'd9, 0);
    issue(MDU_MTLO, 32'h1234, 32'd0, 0);
    rd(MDU_MFLO, "lo_old_during_busy");
    rd(MDU_MFHI, "hi_old_during_busy");
    wait_done();
    rd(MDU_MFLO, "lo_after_ignored_mtlo");

    issue(MDU_MTHI, 32'h55, 32'd0, 0);
    issue(MDU_DIV, 32'd1000, 32'd7, 3);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    m_pending = 1'b0;
    m_hi      = 32'd0;
    m_lo      = 32'd0;
    rd(MDU_MFHI, "abort_hi");
    rd(MDU_MFLO, "abort_lo");
    repeat (12) @(posedge clk);
    #1;
    rd(MDU_MFHI, "abort_no_late_hi");
    rd(MDU_MFLO, "abort_no_late_lo");

    for (int i = 0; i < 60; i++) begin
      r  = int'($urandom_range(0, 5));
      op = 3'((r < 4) ? r : r + 2);
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 9);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      run_op(op, a, b, "random");
    end

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d busy and %0d read expectations left, expected 0 and 0",
               busy_q.size(), exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
